// File: rtl/serial_subtractor32_if.sv
// Handshake and data bundle for serial_subtractor32.
//   master : operand source / result consumer (drives operands, in_valid, out_ready)
//   slave  : the subtractor (drives in_ready, out_valid and the result fields)
interface serial_subtractor32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sub_in0;
  logic [31:0] sub_in1;
  logic        borrow_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sub_out;
  logic        borrow_out;
  logic        overflow;
  logic        zero;

  modport master (
    output in_valid, sub_in0, sub_in1, borrow_in, out_ready,
    input  in_ready, out_valid, sub_out, borrow_out, overflow, zero
  );

  modport slave (
    input  in_valid, sub_in0, sub_in1, borrow_in, out_ready,
    output in_ready, out_valid, sub_out, borrow_out, overflow, zero
  );
endinterface

// File: rtl/serial_subtractor32.sv
// Serial 32-bit subtractor: computes sub_in0 - sub_in1 - borrow_in as
// sub_in0 + ~sub_in1 + ~borrow_in, SLICE_W bits per clock.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  serial_subtractor32_if.slave (operands/handshake in, result/flags out)
//
// state | meaning
// IDLE  | waiting for operands (in_ready = 1)
// BUSY  | adding one slice per cycle, NSLICE cycles
// DONE  | result held on outputs (out_valid = 1) until out_ready
module serial_subtractor32 #(
  parameter int SLICE_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  serial_subtractor32_if.slave bus
);
  localparam int NSLICE = 32 / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (!(SLICE_W == 1 || SLICE_W == 2 || SLICE_W == 4 ||
        SLICE_W == 8 || SLICE_W == 16 || SLICE_W == 32)) begin : g_bad_slice
    $error("serial_subtractor32: SLICE_W must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        opa, opb, res;
  logic               carry;
  logic               sign0, sign1;
  logic [CNT_W-1:0]   cnt;
  logic [SLICE_W:0]   slice_sum;
  logic [31+SLICE_W:0] res_cat;
  logic [31:0]        res_nxt;
  logic               last;

  assign slice_sum = {1'b0, opa[SLICE_W-1:0]} + {1'b0, opb[SLICE_W-1:0]}
                   + {{SLICE_W{1'b0}}, carry};
  // New slice enters at the top; after NSLICE shifts slice 0 sits at bit 0.
  assign res_cat   = {slice_sum[SLICE_W-1:0], res};
  assign res_nxt   = res_cat[31+SLICE_W:SLICE_W];
  assign last      = (cnt == CNT_W'(NSLICE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid && bus.in_ready) state_nxt = BUSY;
      BUSY:    if (last)                         state_nxt = DONE;
      DONE:    if (bus.out_ready)                state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so both read 0 while
  // rst is high and in_ready appears at the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.in_ready   <= 1'b0;
      bus.out_valid  <= 1'b0;
      opa            <= '0;
      opb            <= '0;
      res            <= '0;
      carry          <= 1'b0;
      sign0          <= 1'b0;
      sign1          <= 1'b0;
      cnt            <= '0;
      bus.sub_out    <= '0;
      bus.borrow_out <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.zero       <= 1'b0;
    end else begin
      bus.in_ready  <= (state_nxt == IDLE);
      bus.out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            opa   <= bus.sub_in0;
            opb   <= ~bus.sub_in1;
            carry <= ~bus.borrow_in;
            sign0 <= bus.sub_in0[31];
            sign1 <= bus.sub_in1[31];
            cnt   <= '0;
          end
        end
        BUSY: begin
          opa   <= opa >> SLICE_W;
          opb   <= opb >> SLICE_W;
          res   <= res_nxt;
          carry <= slice_sum[SLICE_W];
          cnt   <= cnt + 1'b1;
          if (last) begin
            bus.sub_out    <= res_nxt;
            bus.borrow_out <= ~slice_sum[SLICE_W];
            bus.overflow   <= (sign0 != sign1) && (res_nxt[31] != sign0);
            bus.zero       <= (res_nxt == 32'd0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor32.sv
module tb_serial_subtractor32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor32_if bus();
  serial_subtractor32 dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] diff;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  res_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  time  acc_time;

  // Reference: plain 33-bit arithmetic; bit 32 of the wrapped result is the borrow.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] w;
    res_t r;
    w      = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    r.diff = w[31:0];
    r.bo   = w[32];
    r.ov   = (a[31] != b[31]) && (w[31] != a[31]);
    r.z    = (w[31:0] == 32'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Every DONE cycle is checked against the oldest outstanding model result.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out_valid: got result %h, want no result", bus.sub_out);
      end else begin
        chk("model_sub_out",    bus.sub_out,           exp_q[0].diff);
        chk("model_borrow_out", 32'(bus.borrow_out),   32'(exp_q[0].bo));
        chk("model_overflow",   32'(bus.overflow),     32'(exp_q[0].ov));
        chk("model_zero",       32'(bus.zero),         32'(exp_q[0].z));
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready && exp_q.size() > 0)
      void'(exp_q.pop_front());
  end

  // Present operands, wait for accept, then wait for out_valid (bounded).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       input logic ready, output bit ok);
    int n;
    ok            = 1'b0;
    bus.sub_in0   = a;
    bus.sub_in1   = b;
    bus.borrow_in = bin;
    bus.out_ready = ready;
    bus.in_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_time = $time;
    exp_q.push_back(model(a, b, bin));
    #1;
    bus.in_valid  = 1'b0;
    bus.sub_in0   = $urandom;
    bus.sub_in1   = $urandom;
    bus.borrow_in = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.out_valid && n < 50);
    chk("latency", 32'(n), 32'd8);
    ok = bus.out_valid;
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input logic [31:0] ed, input logic ebo,
                          input logic eov, input logic ez);
    bit ok;
    do_op(a, b, bin, 1'b1, ok);
    if (ok) begin
      chk({name, "_diff"},     bus.sub_out,         ed);
      chk({name, "_borrow"},   32'(bus.borrow_out), 32'(ebo));
      chk({name, "_overflow"}, 32'(bus.overflow),   32'(eov));
      chk({name, "_zero"},     32'(bus.zero),       32'(ez));
      @(posedge clk);
      #1;
      chk({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({name, "_ready_back"}, 32'(bus.in_ready),  32'd1);
      chk({name, "_retained"},   bus.sub_out,        ed);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    time  prev;
    logic [31:0] a, b;
    logic        bin;

    bus.in_valid  = 1'b0;
    bus.sub_in0   = '0;
    bus.sub_in1   = '0;
    bus.borrow_in = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),   32'd0);
    chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("rst_sub_out",   bus.sub_out,         32'd0);
    chk("rst_flags",     {29'd0, bus.borrow_out, bus.overflow, bus.zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_edge_in_ready", 32'(bus.in_ready), 32'd1);

    directed("all_ones",   32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    directed("underflow",  32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    directed("signed_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    directed("zero_res",   32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: result must stay put while inputs churn.
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        bus.in_valid  = ~bus.in_valid;
        bus.sub_in0   = $urandom;
        bus.sub_in1   = $urandom;
        bus.borrow_in = ~bus.borrow_in;
        @(negedge clk);
        chk("bp_sub_out",   bus.sub_out,          32'h0123_4567);
        chk("bp_flags",     {29'd0, bus.borrow_out, bus.overflow, bus.zero}, 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid),   32'd1);
        chk("bp_in_ready",  32'(bus.in_ready),    32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_release_ready", 32'(bus.in_ready),  32'd1);
      chk("bp_retained",      bus.sub_out,        32'h0123_4567);
    end

    directed("zero_again", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Reset at BUSY cycle 3: aborted result must never surface.
    bus.sub_in0   = 32'hDEAD_BEEF;
    bus.sub_in1   = 32'h0000_0001;
    bus.borrow_in = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    chk("abort_accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_in_ready",  32'(bus.in_ready),  32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_sub_out",   bus.sub_out,        32'd0);
    chk("abort_flags",     {29'd0, bus.borrow_out, bus.overflow, bus.zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready_after", 32'(bus.in_ready), 32'd1);
    directed("after_abort", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

    // Back-to-back operations with out_ready held high: one per 10 cycles.
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      a   = $urandom;
      b   = $urandom;
      bin = 1'($urandom_range(0, 1));
      if (i == 0) b = a;
      do_op(a, b, bin, 1'b1, ok);
      if (ok) begin
        if (i > 0) chk("throughput_ns", 32'(acc_time - prev), 32'd100);
        prev = acc_time;
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_subtractor32.md
SERIAL_SUBTRACTOR32 -- requirements
Module: serial_subtractor32

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-high.
REQ-002 Parameter SLICE_W SHALL default to 4, set the bits processed per cycle, and be limited to 1, 2, 4, 8, 16 or 32; NSLICE = 32/SLICE_W.
REQ-003 The ports SHALL be as follows, one per line:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- sub_in0  input  32  minuend.
- sub_in1  input  32  subtrahend.
- borrow_in  input  1  incoming borrow.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sub_out  output  32  difference, sub_in0 - sub_in1 - borrow_in, mod 2^32.
- borrow_out  output  1  unsigned borrow (1 when the unsigned minuend < subtrahend + borrow_in).
- overflow  output  1  two's-complement overflow.
- zero  output  1  sub_out == 0.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-005 in_ready SHALL equal 1 only in IDLE, and out_valid SHALL equal 1 only in DONE.
REQ-006 In IDLE, an accept (in_valid & in_ready at a rising edge) SHALL:
- latch sub_in0, ~sub_in1 and carry = ~borrow_in;
- clear the slice counter;
- enter BUSY.
REQ-007 In BUSY, each cycle SHALL add the lowest SLICE_W bits of both latched operands plus carry.
- Shift the slice sum into the result register from the top.
- Update carry.
- Increment the counter.
REQ-008 After NSLICE BUSY cycles, the FSM SHALL enter DONE, with out_valid rising exactly NSLICE cycles after the accepting edge (8 cycles at default).
REQ-009 On entering DONE, the block SHALL register the following outputs:
- sub_out = result;
- borrow_out = ~final carry;
- overflow = (sub_in0[31] != sub_in1[31]) & (sub_out[31] != sub_in0[31]), evaluated on the latched operands;
- zero = (sub_out == 0).
REQ-010 In DONE, all outputs SHALL hold stable until out_ready = 1; out_valid & out_ready at an edge SHALL return the FSM to IDLE.
REQ-011 The block SHALL NOT accept a new operation in the same cycle as the output handshake; in_ready SHALL rise the cycle after DONE exits.
REQ-012 While in BUSY or DONE, the block SHALL ignore changes on in_valid, sub_in0, sub_in1 and borrow_in.
REQ-013 sub_out, borrow_out, overflow and zero SHALL retain the last result after leaving DONE until the next DONE entry.
REQ-014 out_ready asserted outside DONE SHALL have no effect.
REQ-015 Throughput SHALL be one operation per NSLICE+2 cycles when out_ready is held at 1.

Reset
REQ-016 rst = 1 SHALL, asynchronously, force the FSM to IDLE and clear all internal state.
- Internal state: operand registers, carry, counter, result register.
REQ-017 While rst = 1, the outputs SHALL be:
- in_ready = 0;
- out_valid = 0;
- sub_out = 32'h00000000;
- borrow_out = 0, overflow = 0, zero = 0.
REQ-018 After rst deasserts, in_ready SHALL rise at the first rising edge.
REQ-019 Reset asserted during BUSY or DONE SHALL abort the operation with no out_valid pulse, and the aborted result SHALL never appear.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- 0xFFFFFFFF - 0x00000000, borrow_in 0 -> sub_out 0xFFFFFFFF; borrow_out 0, overflow 0, zero 0; out_valid exactly 8 cycles after accept.
- 0x00000000 - 0x00000001, borrow_in 0 -> sub_out 0xFFFFFFFF; borrow_out 1, overflow 0.
- 0x80000000 - 0x00000001, borrow_in 0 -> sub_out 0x7FFFFFFF; overflow 1, borrow_out 0.
- 0x00000000 - 0xFFFFFFFF, borrow_in 1 -> sub_out 0x00000000; zero 1, borrow_out 1, overflow 0.
- Backpressure: hold out_ready 0 for 5 cycles in DONE while toggling the inputs and in_valid -> outputs stable, in_ready 0; then out_ready 1 -> IDLE; in_ready rises the next cycle.
- Reset pulse at BUSY cycle 3 -> outputs are zero immediately, no out_valid occurs, and the next operation (5 - 3) gives 0x00000002.
